mem_arbiter: RTL and testbench

Two-requester arbiter and sequencer that shares the single data-side port of the unified memory controller between the instruction fetch unit (IFU) and the load/store unit (LSU). It accepts at most one request per cycle, drives the memory port, captures the one-cycle-latency read data, and routes a response back to the requester that issued the access. Misaligned requests are rejected locally without touching memory. It sits between the pipeline front/back ends and the memory controller.

---
 rtl/utils_pkg.sv | 61 ++++++
 rtl/mem_align_check.sv | 31 +++
 rtl/mem_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/utils_pkg.sv
// Shared types and helpers for the memory-side blocks.
// Holds datapath widths, width codes, the arbiter FSM state and load extension.
// Pure declarations; no latency or backpressure of its own.
package utils_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int INST_WIDTH = 32;

  // Memory access width codes
  localparam logic [2:0] MEM_B  = 3'd0;
  localparam logic [2:0] MEM_H  = 3'd1;
  localparam logic [2:0] MEM_W  = 3'd2;
  localparam logic [2:0] MEM_D  = 3'd3;
  localparam logic [2:0] MEM_BU = 3'd4;
  localparam logic [2:0] MEM_HU = 3'd5;
  localparam logic [2:0] MEM_WU = 3'd6;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_RESP_I = 2'd1,
    ARB_RESP_L = 2'd2
  } arb_state_e;

  // Sign-extend the low 2**sz bytes of v
  function automatic logic [DATA_WIDTH-1:0] sext(input logic [DATA_WIDTH-1:0] v,
                                                 input logic [1:0] sz);
    case (sz)
      2'd0:    return {{(DATA_WIDTH-8){v[7]}}, v[7:0]};
      2'd1:    return {{(DATA_WIDTH-16){v[15]}}, v[15:0]};
      2'd2:    return {{(DATA_WIDTH-32){v[31]}}, v[31:0]};
      default: return v;
    endcase
  endfunction

  // Zero-extend the low 2**sz bytes of v
  function automatic logic [DATA_WIDTH-1:0] zext(input logic [DATA_WIDTH-1:0] v,
                                                 input logic [1:0] sz);
    case (sz)
      2'd0:    return {{(DATA_WIDTH-8){1'b0}}, v[7:0]};
      2'd1:    return {{(DATA_WIDTH-16){1'b0}}, v[15:0]};
      2'd2:    return {{(DATA_WIDTH-32){1'b0}}, v[31:0]};
      default: return v;
    endcase
  endfunction

  // Extend already lane-shifted load data according to its width code
  function automatic logic [DATA_WIDTH-1:0] load_extend(input logic [DATA_WIDTH-1:0] raw,
                                                        input logic [2:0] wid);
    case (wid)
      MEM_B:   return sext(raw, 2'd0);
      MEM_H:   return sext(raw, 2'd1);
      MEM_W:   return sext(raw, 2'd2);
      MEM_D:   return raw;
      MEM_BU:  return zext(raw, 2'd0);
      MEM_HU:  return zext(raw, 2'd1);
      MEM_WU:  return zext(raw, 2'd2);
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/mem_align_check.sv
// Alignment / legality check for a single memory request.
// Purely combinational, zero latency.
// No handshake; evaluated on whichever request is being granted.
module mem_align_check
  import utils_pkg::*;
(
  input  logic [2:0] wid_i,
  input  logic [2:0] addr_i,
  input  logic       is_ifu_i,
  output logic       misalign_o,
  output logic       illegal_o
);

  // Fetches are always word sized; LSU checks depend on the width code
  always_comb begin
    misalign_o = 1'b0;
    illegal_o  = 1'b0;
    if (is_ifu_i) begin
      misalign_o = (addr_i[1:0] != 2'b00);
    end else begin
      case (wid_i)
        MEM_B, MEM_BU: misalign_o = 1'b0;
        MEM_H, MEM_HU: misalign_o = addr_i[0];
        MEM_W, MEM_WU: misalign_o = (addr_i[1:0] != 2'b00);
        MEM_D:         misalign_o = (addr_i != 3'b000);
        default:       illegal_o  = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// IFU/LSU arbiter sharing one memory port; LSU wins (IFU anti-starvation under MEM_ARB_STARVE_GUARD_EN).
// Latency: grant in cycle N, response valid in cycle N+1; one access per cycle sustained.
// Backpressure: requesters hold req/payload until their ready_o pulses; responses cannot be stalled.
module mem_arbiter
  import utils_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_BITS    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ifu_req_i,
  input  logic [DATA_WIDTH-1:0] ifu_addr_i,
  output logic                  ifu_ready_o,
  output logic                  ifu_valid_o,
  output logic [INST_WIDTH-1:0] ifu_inst_o,
  output logic                  ifu_err_o,
  input  logic                  lsu_req_i,
  input  logic                  lsu_we_i,
  input  logic [2:0]            lsu_wid_i,
  input  logic [DATA_WIDTH-1:0] lsu_addr_i,
  input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
  output logic                  lsu_ready_o,
  output logic                  lsu_valid_o,
  output logic [DATA_WIDTH-1:0] lsu_rdata_o,
  output logic                  lsu_err_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [ADDR_BITS-1:0]  mem_addr_o,
  output logic [2:0]            mem_wid_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic [INST_WIDTH-1:0] mem_inst_i
);

  arb_state_e state_q, state_d;
  logic       err_q, err_d;
  logic       store_q, store_d;
  logic [2:0] wid_q, wid_d;
  logic [2:0] off_q, off_d;

  logic       gnt_i, gnt_l;
  logic       ifu_force;
  logic       chk_misalign, chk_illegal, req_bad;
  logic [2:0] chk_addr;

  // Only the low ADDR_BITS of each address reach memory
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ifu_addr_i[DATA_WIDTH-1:ADDR_BITS],
                              lsu_addr_i[DATA_WIDTH-1:ADDR_BITS]};

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] starve_q, starve_d;

  assign ifu_force = ifu_req_i && (starve_q == CW'(STARVE_LIMIT));

  // Count LSU wins while the IFU is waiting; saturate at the limit
  always_comb begin
    starve_d = starve_q;
    if (!ifu_req_i || gnt_i) begin
      starve_d = '0;
    end else if (gnt_l && (starve_q != CW'(STARVE_LIMIT))) begin
      starve_d = starve_q + CW'(1);
    end
  end

  // Starvation counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign ifu_force = 1'b0;
`endif

  // Grants are masked while reset is held so every output stays quiet
  assign gnt_l       = rst_n && lsu_req_i && !ifu_force;
  assign gnt_i       = rst_n && ifu_req_i && !gnt_l;
  assign ifu_ready_o = gnt_i;
  assign lsu_ready_o = gnt_l;

  assign chk_addr = gnt_i ? ifu_addr_i[2:0] : lsu_addr_i[2:0];
  assign req_bad  = chk_misalign || chk_illegal;

  mem_align_check u_align (
    .wid_i      (lsu_wid_i),
    .addr_i     (chk_addr),
    .is_ifu_i   (gnt_i),
    .misalign_o (chk_misalign),
    .illegal_o  (chk_illegal)
  );

  // Drive the memory port from the granted payload; bad requests never reach memory
  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wid_o   = '0;
    mem_wdata_o = '0;
    if (gnt_l && !req_bad) begin
      mem_en_o    = 1'b1;
      mem_we_o    = lsu_we_i;
      mem_addr_o  = lsu_addr_i[ADDR_BITS-1:0];
      mem_wid_o   = lsu_wid_i;
      mem_wdata_o = lsu_wdata_i;
    end else if (gnt_i && !req_bad) begin
      mem_en_o   = 1'b1;
      mem_addr_o = ifu_addr_i[ADDR_BITS-1:0];
      mem_wid_o  = MEM_W;
    end
  end

  // Next state follows this cycle's grant; capture what the response needs
  always_comb begin
    state_d = ARB_IDLE;
    err_d   = 1'b0;
    store_d = 1'b0;
    wid_d   = MEM_W;
    off_d   = 3'b000;
    if (gnt_l) begin
      state_d = ARB_RESP_L;
      err_d   = req_bad;
      store_d = lsu_we_i;
      wid_d   = lsu_wid_i;
      off_d   = lsu_addr_i[2:0];
    end else if (gnt_i) begin
      state_d = ARB_RESP_I;
      err_d   = req_bad;
    end
  end

  // FSM and response-context registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      err_q   <= 1'b0;
      store_q <= 1'b0;
      wid_q   <= MEM_W;
      off_q   <= 3'b000;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      store_q <= store_d;
      wid_q   <= wid_d;
      off_q   <= off_d;
    end
  end

  // Route the one-cycle-late memory data to the owner of the outstanding access
  always_comb begin
    ifu_valid_o = 1'b0;
    ifu_err_o   = 1'b0;
    ifu_inst_o  = '0;
    lsu_valid_o = 1'b0;
    lsu_err_o   = 1'b0;
    lsu_rdata_o = '0;
    case (state_q)
      ARB_RESP_I: begin
        ifu_valid_o = 1'b1;
        ifu_err_o   = err_q;
        if (!err_q) ifu_inst_o = mem_inst_i;
      end
      ARB_RESP_L: begin
        lsu_valid_o = 1'b1;
        lsu_err_o   = err_q;
        if (!err_q && !store_q) lsu_rdata_o = load_extend(mem_rdata_i >> {off_q, 3'b000}, wid_q);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed table, hand sequences, random vs reference model.
module tb_mem_arbiter;
  import utils_pkg::*;

  localparam int STARVE_LIMIT = 4;
  localparam int ADDR_BITS    = 16;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  ifu_req_i;
  logic [DATA_WIDTH-1:0] ifu_addr_i;
  logic                  ifu_ready_o, ifu_valid_o, ifu_err_o;
  logic [INST_WIDTH-1:0] ifu_inst_o;
  logic                  lsu_req_i, lsu_we_i;
  logic [2:0]            lsu_wid_i;
  logic [DATA_WIDTH-1:0] lsu_addr_i, lsu_wdata_i;
  logic                  lsu_ready_o, lsu_valid_o, lsu_err_o;
  logic [DATA_WIDTH-1:0] lsu_rdata_o;
  logic                  mem_en_o, mem_we_o;
  logic [ADDR_BITS-1:0]  mem_addr_o;
  logic [2:0]            mem_wid_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o, mem_rdata_i;
  logic [INST_WIDTH-1:0] mem_inst_i;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .ADDR_BITS(ADDR_BITS)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_i(ifu_req_i), .ifu_addr_i(ifu_addr_i), .ifu_ready_o(ifu_ready_o),
    .ifu_valid_o(ifu_valid_o), .ifu_inst_o(ifu_inst_o), .ifu_err_o(ifu_err_o),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_wid_i(lsu_wid_i),
    .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_ready_o(lsu_ready_o),
    .lsu_valid_o(lsu_valid_o), .lsu_rdata_o(lsu_rdata_o), .lsu_err_o(lsu_err_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wid_o(mem_wid_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_inst_i(mem_inst_i)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state: what response is owed next cycle
  bit          m_pend_i, m_pend_l, m_err, m_store;
  logic [2:0]  m_wid, m_off;
  int          m_streak;
  bit          last_g_i, last_g_l;

  function automatic int size_of(input logic [2:0] wid);
    return 1 << (wid % 4);
  endfunction

  function automatic bit lsu_bad(input logic [2:0] wid, input logic [63:0] a);
    if (wid == 3'd7) return 1'b1;
    return (a % size_of(wid)) != 0;
  endfunction

  function automatic logic [63:0] model_load(input logic [63:0] raw, input logic [2:0] wid,
                                             input logic [2:0] off);
    int          n;
    logic [63:0] v, mask;
    n    = size_of(wid);
    v    = raw >> (8 * off);
    mask = (n == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * n)) - 64'd1);
    v    = v & mask;
    if (wid < 3'd4 && n < 8 && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  // Check all outputs of the current cycle against the model, then advance one cycle.
  // Called at negedge+1 with inputs already applied; returns at the next negedge+1.
  task automatic step();
    bit force_i, g_l, g_i, bad, en;
    #1;
    if (!rst_n) begin
      m_pend_i = 0; m_pend_l = 0; m_streak = 0;
    end
    force_i = 1'b0;
`ifdef MEM_ARB_STARVE_GUARD_EN
    force_i = ifu_req_i && (m_streak == STARVE_LIMIT);
`endif
    g_l = rst_n && lsu_req_i && !force_i;
    g_i = rst_n && ifu_req_i && !g_l;
    bad = g_l ? lsu_bad(lsu_wid_i, lsu_addr_i) : ((ifu_addr_i % 4) != 0);
    en  = (g_l || g_i) && !bad;
    chk("ifu_ready", ifu_ready_o, g_i);
    chk("lsu_ready", lsu_ready_o, g_l);
    chk("mem_en", mem_en_o, en);
    chk("mem_we", mem_we_o, en && g_l && lsu_we_i);
    chk("mem_addr", mem_addr_o, !en ? 0 : (g_l ? lsu_addr_i % 65536 : ifu_addr_i % 65536));
    chk("mem_wid", mem_wid_o, !en ? 0 : (g_l ? lsu_wid_i : 3'd2));
    chk("mem_wdata", mem_wdata_o, (en && g_l) ? lsu_wdata_i : 64'd0);
    chk("ifu_valid", ifu_valid_o, m_pend_i);
    chk("ifu_err", ifu_err_o, m_pend_i && m_err);
    chk("ifu_inst", ifu_inst_o, (m_pend_i && !m_err) ? mem_inst_i : 32'd0);
    chk("lsu_valid", lsu_valid_o, m_pend_l);
    chk("lsu_err", lsu_err_o, m_pend_l && m_err);
    chk("lsu_rdata", lsu_rdata_o,
        (m_pend_l && !m_err && !m_store) ? model_load(mem_rdata_i, m_wid, m_off) : 64'd0);
    last_g_i = g_i;
    last_g_l = g_l;
    m_pend_i = g_i;
    m_pend_l = g_l;
    m_err    = bad;
    m_store  = g_l && lsu_we_i;
    m_wid    = lsu_wid_i;
    m_off    = lsu_addr_i[2:0];
    if (!ifu_req_i || g_i || !rst_n) m_streak = 0;
    else if (g_l && m_streak < STARVE_LIMIT) m_streak++;
    @(negedge clk);
    #1;
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  wid;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        exp_err;
    logic        exp_en;
    logic [63:0] exp_out;
  } vec_t;

  vec_t tv[13];
  int   n_ifu_gnt;
  int   exp_ifu_gnt;

  initial begin
    // Directed LSU vectors: payload, memory data in the response cycle, expected result
    tv[0]  = '{1'b0, 3'd1, 64'h3,  64'h0, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0, 64'h0};
    tv[1]  = '{1'b0, 3'd0, 64'h5,  64'h0, 64'h0000_8000_0000_0000, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FF80};
    tv[2]  = '{1'b0, 3'd4, 64'h5,  64'h0, 64'h0000_8000_0000_0000, 1'b0, 1'b1, 64'h80};
    tv[3]  = '{1'b1, 3'd3, 64'h8,  64'h1122_3344_5566_7788, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 64'h0};
    tv[4]  = '{1'b0, 3'd2, 64'h4,  64'h0, 64'h8000_0001_0000_0000, 1'b0, 1'b1, 64'hFFFF_FFFF_8000_0001};
    tv[5]  = '{1'b0, 3'd6, 64'h4,  64'h0, 64'h8000_0001_0000_0000, 1'b0, 1'b1, 64'h8000_0001};
    tv[6]  = '{1'b0, 3'd5, 64'h6,  64'h0, 64'hFEDC_0000_0000_0000, 1'b0, 1'b1, 64'hFEDC};
    tv[7]  = '{1'b0, 3'd1, 64'h2,  64'h0, 64'h0000_0000_8001_0000, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_8001};
    tv[8]  = '{1'b0, 3'd3, 64'h10, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 1'b1, 64'hDEAD_BEEF_CAFE_F00D};
    tv[9]  = '{1'b0, 3'd3, 64'h4,  64'h0, 64'hDEAD_BEEF_CAFE_F00D, 1'b1, 1'b0, 64'h0};
    tv[10] = '{1'b0, 3'd7, 64'h0,  64'h0, 64'hDEAD_BEEF_CAFE_F00D, 1'b1, 1'b0, 64'h0};
    tv[11] = '{1'b0, 3'd2, 64'h6,  64'h0, 64'hDEAD_BEEF_CAFE_F00D, 1'b1, 1'b0, 64'h0};
    tv[12] = '{1'b1, 3'd0, 64'h3,  64'hAB, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 1'b1, 64'h0};

    m_pend_i = 0; m_pend_l = 0; m_err = 0; m_store = 0; m_wid = 0; m_off = 0; m_streak = 0;
    last_g_i = 0; last_g_l = 0;

    // Reset with both requesters active: every output must stay 0
    rst_n = 1'b0;
    ifu_req_i = 1'b1; ifu_addr_i = 64'h0;
    lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_wid_i = 3'd3; lsu_addr_i = 64'h8; lsu_wdata_i = 64'h55;
    mem_rdata_i = 64'hFFFF_FFFF_FFFF_FFFF; mem_inst_i = 32'hFFFF_FFFF;
    step();
    rst_n = 1'b1; ifu_req_i = 1'b0; lsu_req_i = 1'b0;
    step();

    // Directed LSU table: grant cycle, then response cycle
    for (int i = 0; i < 13; i++) begin
      lsu_req_i = 1'b1; lsu_we_i = tv[i].we; lsu_wid_i = tv[i].wid;
      lsu_addr_i = tv[i].addr; lsu_wdata_i = tv[i].wdata;
      #1 chk($sformatf("tv%0d_en", i), mem_en_o, tv[i].exp_en);
      step();
      lsu_req_i = 1'b0; mem_rdata_i = tv[i].rdata;
      #1;
      chk($sformatf("tv%0d_valid", i), lsu_valid_o, 1'b1);
      chk($sformatf("tv%0d_err", i), lsu_err_o, tv[i].exp_err);
      chk($sformatf("tv%0d_rdata", i), lsu_rdata_o, tv[i].exp_out);
      step();
    end

    // IFU-only fetch stream at 0x0, 0x4, 0x8, responses back to back
    for (int i = 0; i < 3; i++) begin
      ifu_req_i = 1'b1; ifu_addr_i = 64'(4 * i); mem_inst_i = 32'h1000_0000 + 32'(i);
      #1 chk("ifu_stream_ready", ifu_ready_o, 1'b1);
      step();
    end
    ifu_req_i = 1'b0; mem_inst_i = 32'hCAFE_0003;
    #1 chk("ifu_stream_last_valid", ifu_valid_o, 1'b1);
    step();

    // Simultaneous requests at 0x10: LSU first, then IFU, responses L then I
    ifu_req_i = 1'b1; ifu_addr_i = 64'h10;
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_wid_i = 3'd3; lsu_addr_i = 64'h10;
    #1 chk("both_lsu_first", {ifu_ready_o, lsu_ready_o}, 2'b01);
    step();
    lsu_req_i = 1'b0;
    #1 chk("both_ifu_second", {ifu_ready_o, lsu_valid_o}, 2'b11);
    step();
    ifu_req_i = 1'b0;
    #1 chk("both_ifu_resp", {ifu_valid_o, lsu_valid_o}, 2'b10);
    step();

    // Reset in the response cycle of an LSU load discards the response
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_wid_i = 3'd2; lsu_addr_i = 64'h20;
    step();
    lsu_req_i = 1'b0; rst_n = 1'b0;
    #1 chk("rst_mid_valid", lsu_valid_o, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    #1 chk("rst_after_valid", lsu_valid_o, 1'b0);
    step();

    // Continuous contention: IFU starves unless the guard is built in
    n_ifu_gnt = 0;
    ifu_req_i = 1'b1; ifu_addr_i = 64'h40;
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_wid_i = 3'd3; lsu_addr_i = 64'h48;
    for (int c = 0; c < 20; c++) begin
      step();
      if (last_g_i) n_ifu_gnt++;
    end
`ifdef MEM_ARB_STARVE_GUARD_EN
    exp_ifu_gnt = 20 / (STARVE_LIMIT + 1);
`else
    exp_ifu_gnt = 0;
`endif
    chk("starve_ifu_grants", 64'(n_ifu_gnt), 64'(exp_ifu_gnt));
    ifu_req_i = 1'b0; lsu_req_i = 1'b0;
    step();

    // Random traffic against the reference model, payloads held until accepted
    for (int c = 0; c < 400; c++) begin
      if (!ifu_req_i || last_g_i) begin
        ifu_req_i  = 1'($urandom_range(0, 1));
        ifu_addr_i = {$urandom, $urandom};
        if ($urandom_range(0, 3) != 0) ifu_addr_i[1:0] = 2'b00;
      end
      if (!lsu_req_i || last_g_l) begin
        lsu_req_i   = 1'($urandom_range(0, 1));
        lsu_we_i    = 1'($urandom_range(0, 1));
        lsu_wid_i   = 3'($urandom_range(0, 7));
        lsu_addr_i  = {$urandom, $urandom};
        lsu_wdata_i = {$urandom, $urandom};
        if ($urandom_range(0, 3) != 0) lsu_addr_i[2:0] = 3'b000;
      end
      mem_rdata_i = {$urandom, $urandom};
      mem_inst_i  = $urandom;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
